uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//   Parametrised UART transmitter: serialises one word per valid/ready handshake
//   into start + data + optional parity + 1/2 stop bits on a single line.
//   Internal baud divider replaces the external bit_clk strobe. Sits between a
//   byte producer (FIFO/CPU reg) and the board TX pin, all in the ref_clk domain.
// PARAMETERS
//   DATA_BITS    8   data bits per frame, legal 5..9
//   PARITY       0   0 = none, 1 = even, 2 = odd
//   STOP_BITS    1   stop bits, legal 1 or 2
//   CLKS_PER_BIT 16  ref_clk cycles per bit, legal >= 2
//   LSB_FIRST    1   1 = in_data[0] sent first, 0 = in_data[DATA_BITS-1] first
// PORTS
//   ref_clk   in   1          system clock; all logic on rising edge
//   rst_n     in   1          asynchronous active-low reset
//   in_valid  in   1          producer has a word on in_data
//   in_data   in   DATA_BITS  word to send; sampled only on handshake
//   in_ready  out  1          block can accept a word (state == IDLE)
//   out       out  1          serial line; idle/mark = 1
//   busy      out  1          frame in progress (state != IDLE)
//   done      out  1          one-cycle pulse: frame complete
// BEHAVIOUR
//   Reset (async, rst_n=0): out=1, busy=0, done=0, in_ready=1, state=IDLE,
//     baud counter=0, bit index=0. Reset mid-frame: line returns to 1 at once,
//     frame abandoned, no done pulse.
//   in_ready is combinational = (state == IDLE). Handshake = in_valid & in_ready
//     at a rising edge; in_data latched into shift reg, parity computed from it.
//   Latency: start bit (out=0) appears the cycle after the handshake edge.
//   States: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
//   Every bit held exactly CLKS_PER_BIT cycles; counter runs 0..CLKS_PER_BIT-1,
//     bit advances when counter == CLKS_PER_BIT-1.
//   DATA: DATA_BITS bits, order per LSB_FIRST. Bit index width $clog2(DATA_BITS+1).
//   PARITY: even -> bit = ^data; odd -> bit = ~^data (data as latched).
//   STOP: out=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   Frame length N = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
//   On last cycle of STOP: state->IDLE, done=1 for the following single cycle,
//     coincident with in_ready=1 and out=1.
//   Back-to-back: a handshake in the done cycle starts the next start bit the
//     cycle after, so stop+idle time between frames is STOP_BITS*CLKS_PER_BIT+1.
//   in_data / in_valid changes while busy are ignored; no word is dropped or
//     accepted outside IDLE.
//   Illegal parameter values: elaboration-time $error, no runtime handling.
// TESTING
//   1 Reset: hold rst_n=0 mid-frame -> out=1, in_ready=1, busy=0, done=0
//     immediately; release, send 0x3C -> correct frame, no stale bits.
//   2 Defaults, CLKS_PER_BIT=4: handshake 0xA5 at edge 0 -> out 0 for cycles 1-4,
//     then 1,0,1,0,0,1,0,1 each 4 cycles, stop 1 cycles 37-40; done=1 cycle 41.
//   3 PARITY=1, 0x07 -> parity bit 1; PARITY=2, 0x07 -> 0; PARITY=1, 0x00 -> 0.
//   4 DATA_BITS=7, STOP_BITS=2, LSB_FIRST=0, 0x41 -> 0,1,0,0,0,0,0,1,1,1;
//     frame 10*CLKS_PER_BIT cycles.
//   5 in_valid held, 0x55 then 0xAA -> second accepted in done cycle; line high
//     exactly CLKS_PER_BIT+1 cycles between frames; in_ready=0 throughout frames.
//   6 Change in_data every cycle while busy -> transmitted word = handshake value;
//     bench serial decoder checks all frames against a reference model.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with an internal baud divider.
// Sends start + data + optional parity + 1/2 stop bits for each accepted word.
module uart_tx_frame #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned LSB_FIRST    = 1
) (
  input  logic                 ref_clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  // Parameter legality is checked once at elaboration.
  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (LSB_FIRST > 1) begin : g_bad_lsb_first
      $error("uart_tx_frame: LSB_FIRST must be 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic                 bit_end_c;
  logic                 next_bit_c;
  logic [DATA_BITS-1:0] shreg_shift_c;
  logic                 parity_c;

  // Handshake readiness, end-of-bit strobe, next serial data bit and parity of the offered word.
  assign in_ready      = (state == S_IDLE);
  assign bit_end_c     = (cnt == CNT_LAST);
  assign next_bit_c    = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_BITS-1];
  assign shreg_shift_c = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
  assign parity_c      = (PARITY == 2) ? ~(^in_data) : (^in_data);

  // Frame sequencer: baud counter, bit index, shift register and registered line/status outputs.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      out     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE) begin
        cnt <= bit_end_c ? '0 : (cnt + CNT_W'(1));
      end
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          out     <= 1'b1;
          if (in_valid) begin
            shreg   <= in_data;
            par_bit <= parity_c;
            state   <= S_START;
            out     <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end_c) begin
            out     <= next_bit_c;
            shreg   <= shreg_shift_c;
            bit_idx <= IDX_ONE;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end_c) begin
            if (bit_idx == DATA_LAST) begin
              if (PARITY != 0) begin
                out   <= par_bit;
                state <= S_PARITY;
              end else begin
                out     <= 1'b1;
                bit_idx <= IDX_ONE;
                state   <= S_STOP;
              end
            end else begin
              out     <= next_bit_c;
              shreg   <= shreg_shift_c;
              bit_idx <= bit_idx + IDX_ONE;
            end
          end
        end
        S_PARITY: begin
          if (bit_end_c) begin
            out     <= 1'b1;
            bit_idx <= IDX_ONE;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end_c) begin
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + IDX_ONE;
            end
          end
        end
        default: begin
          out   <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: four differently configured transmitters driven with directed and random
// words; a serial decoder monitor compares every frame against a reference frame model.
module tb_uart_tx_frame;

  localparam int NI = 4;

  // Per-instance configuration: 8N1, 8E1, 8O2, 7N2 MSB-first.
  function automatic int db_of(input int k);
    return (k == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(input int k);
    return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
  endfunction
  function automatic int sb_of(input int k);
    return (k >= 2) ? 2 : 1;
  endfunction
  function automatic int cpb_of(input int k);
    return (k == 2) ? 5 : ((k == 3) ? 3 : 4);
  endfunction
  function automatic int lsb_of(input int k);
    return (k == 3) ? 0 : 1;
  endfunction
  function automatic int frame_len(input int k);
    return cpb_of(k) * (1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + sb_of(k));
  endfunction

  // Reference frame: line level of each bit slot, slot 0 = start bit; unused slots are 1.
  function automatic logic [15:0] frame_bits(input int k, input logic [8:0] w);
    logic [15:0] b;
    int pos;
    int ones;
    b = '1;
    b[0] = 1'b0;
    pos = 1;
    ones = 0;
    for (int i = 0; i < db_of(k); i++) begin
      b[pos] = (lsb_of(k) != 0) ? w[i] : w[db_of(k) - 1 - i];
      ones += int'(w[i]);
      pos++;
    end
    if (par_of(k) == 1) b[pos] = ((ones % 2) == 1);
    else if (par_of(k) == 2) b[pos] = ((ones % 2) == 0);
    return b;
  endfunction

  typedef struct {
    int          inst;
    logic [15:0] bits;
    int          gap;
    logic [8:0]  word;
  } exp_t;

  logic ref_clk;
  logic rst_n;
  logic [NI-1:0]      in_valid;
  logic [NI-1:0][8:0] in_data;
  logic [NI-1:0]      in_ready;
  logic [NI-1:0]      line;
  logic [NI-1:0]      busy;
  logic [NI-1:0]      done;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  bit   timeout_flag;
  bit   fin_req;
  bit   fin_ack;

  logic [NI-1:0] act;
  logic [NI-1:0] done_due;
  int            cyc      [NI];
  int            errs     [NI];
  int            idle_cnt [NI];
  logic [15:0]   cur_bits [NI];
  logic [8:0]    cur_word [NI];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int DB = db_of(g);
      uart_tx_frame #(
        .DATA_BITS   (DB),
        .PARITY      (par_of(g)),
        .STOP_BITS   (sb_of(g)),
        .CLKS_PER_BIT(cpb_of(g)),
        .LSB_FIRST   (lsb_of(g))
      ) u_dut (
        .ref_clk (ref_clk),
        .rst_n   (rst_n),
        .in_valid(in_valid[g]),
        .in_data (in_data[g][DB-1:0]),
        .in_ready(in_ready[g]),
        .out     (line[g]),
        .busy    (busy[g]),
        .done    (done[g])
      );
    end
  endgenerate

  initial begin
    ref_clk = 1'b0;
    forever #5 ref_clk = ~ref_clk;
  end

  task automatic check(input bit ok, input string name, input int k, input int actual, input int expected);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0d expected=%0d t=%0t", name, k, actual, expected, $time);
    end
  endtask

  // Monitor: decodes each line at the falling edge and pops expected frames from the scoreboard.
  initial begin
    checks = 0;
    failures = 0;
    fin_ack = 1'b0;
    act = '0;
    done_due = '0;
    for (int k = 0; k < NI; k++) begin
      cyc[k] = 0; errs[k] = 0; idle_cnt[k] = 0; cur_bits[k] = '1; cur_word[k] = '0;
    end
    forever begin
      @(negedge ref_clk);
      if (!rst_n) begin
        exp_q.delete();
        for (int k = 0; k < NI; k++) begin
          check(line[k] && !busy[k] && !done[k] && in_ready[k], "reset_outputs", k,
                int'({line[k], busy[k], done[k], in_ready[k]}), 9);
          act[k] = 1'b0;
          done_due[k] = 1'b0;
          idle_cnt[k] = 0;
        end
      end else begin
        for (int k = 0; k < NI; k++) begin
          check(in_ready[k] == !busy[k], "ready_vs_busy", k, int'(in_ready[k]), int'(!busy[k]));
          check(done[k] == done_due[k], "done_pulse", k, int'(done[k]), int'(done_due[k]));
          if (done_due[k]) begin
            check(in_ready[k] && line[k], "done_ready_line", k, int'({in_ready[k], line[k]}), 3);
            done_due[k] = 1'b0;
          end
          if (!act[k] && !line[k]) begin
            int idx;
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
              if (idx < 0 && exp_q[i].inst == k) idx = i;
            end
            check(idx >= 0, "unexpected_start", k, idx, 0);
            if (idx >= 0) begin
              if (exp_q[idx].gap >= 0)
                check(idle_cnt[k] == exp_q[idx].gap, "b2b_idle_cycles", k, idle_cnt[k], exp_q[idx].gap);
              cur_bits[k] = exp_q[idx].bits;
              cur_word[k] = exp_q[idx].word;
              exp_q.delete(idx);
              act[k] = 1'b1;
              cyc[k] = 0;
              errs[k] = 0;
            end
          end
          if (act[k]) begin
            if (line[k] !== cur_bits[k][cyc[k] / cpb_of(k)]) errs[k]++;
            if (in_ready[k]) errs[k]++;
            cyc[k]++;
            if (cyc[k] == frame_len(k)) begin
              if (errs[k] != 0)
                $display("FAIL frame_word inst=%0d word=0x%0h bad_cycles=%0d", k, cur_word[k], errs[k]);
              check(errs[k] == 0, "frame", k, errs[k], 0);
              act[k] = 1'b0;
              done_due[k] = 1'b1;
              idle_cnt[k] = 0;
            end
          end else begin
            idle_cnt[k]++;
          end
        end
      end
      if (fin_req && !fin_ack) begin
        check(!timeout_flag, "wait_timeout", 0, int'(timeout_flag), 0);
        check(exp_q.size() == 0, "scoreboard_drained", 0, exp_q.size(), 0);
        fin_ack = 1'b1;
      end
    end
  end

  // Offer one word; while the instance is busy, in_valid/in_data are randomly disturbed.
  task automatic send(input int k, input logic [8:0] w, input bit hold);
    int n;
    exp_t e;
    n = 0;
    forever begin
      @(negedge ref_clk);
      if (in_ready[k]) break;
      if (n >= 300) begin
        timeout_flag = 1'b1;
        in_valid[k] = 1'b0;
        return;
      end
      n++;
      in_valid[k] = 1'($urandom_range(0, 1));
      in_data[k] = 9'($urandom);
    end
    in_valid[k] = 1'b1;
    in_data[k] = w;
    e.inst = k;
    e.bits = frame_bits(k, w);
    e.gap = (n > 0) ? 1 : -1;
    e.word = w;
    exp_q.push_back(e);
    @(posedge ref_clk);
    #1;
    if (!hold) in_valid[k] = 1'b0;
  endtask

  // Wait for every outstanding frame and done pulse, scrambling the idle data buses meanwhile.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 || act != '0 || done_due != '0) begin
      @(negedge ref_clk);
      for (int k = 0; k < NI; k++) in_data[k] = 9'($urandom);
      n++;
      if (n > 600) begin
        timeout_flag = 1'b1;
        return;
      end
    end
    @(negedge ref_clk);
  endtask

  initial begin
    int n;
    int k;
    int words;
    rst_n = 1'b1;
    in_valid = '0;
    in_data = '0;
    timeout_flag = 1'b0;
    fin_req = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge ref_clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge ref_clk);

    send(0, 9'h0A5, 1'b0); drain();
    send(1, 9'h007, 1'b0); drain();
    send(2, 9'h007, 1'b0); drain();
    send(1, 9'h000, 1'b0); drain();
    send(3, 9'h041, 1'b0); drain();

    send(0, 9'h055, 1'b1);
    send(0, 9'h0AA, 1'b0);
    drain();
    send(2, 9'($urandom), 1'b1);
    send(2, 9'($urandom), 1'b1);
    send(2, 9'($urandom), 1'b0);
    drain();

    send(0, 9'($urandom), 1'b0);
    repeat (15) @(posedge ref_clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge ref_clk);
    #1 rst_n = 1'b1;
    repeat (50) @(negedge ref_clk);
    send(0, 9'h03C, 1'b0);
    drain();

    for (int it = 0; it < 30; it++) begin
      k = int'($urandom_range(0, NI - 1));
      words = int'($urandom_range(1, 3));
      for (int j = 0; j < words; j++) send(k, 9'($urandom), j != words - 1);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();

    fin_req = 1'b1;
    n = 0;
    while (!fin_ack && n < 10) begin
      @(negedge ref_clk);
      n++;
    end
    if (!fin_ack) $display("FAIL final_handshake actual=0 expected=1");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
